// File: rtl/xadc_drp_multichannel_sequencer.sv
// Sweeps a table of XADC DRP result registers on every end-of-sequence pulse and
// streams each result as one AXI-Stream beat tagged with channel index and end-of-sweep.
module xadc_drp_multichannel_sequencer #(
    parameter int                          NUM_CHANNELS       = 4,
    parameter logic [NUM_CHANNELS*7-1:0]   CHANNEL_ADDRS      = {7'h13, 7'h1B, 7'h03, 7'h00},
    parameter int                          DATA_WIDTH         = 16,
    parameter int                          DRP_TIMEOUT_CYCLES = 64,
    parameter int                          CNT_WIDTH          = 16
) (
    input  logic                  xadc_dclk,
    input  logic                  xadc_reset_n,
    input  logic                  enable,
    output logic [6:0]            xadc_daddr,
    output logic                  xadc_den,
    input  logic                  xadc_drdy,
    input  logic [DATA_WIDTH-1:0] xadc_do,
    input  logic                  xadc_eos,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [3:0]            m_axis_tid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  overrun_count,
    output logic [CNT_WIDTH-1:0]  timeout_count
);

    // AXI-Stream handshake: a beat transfers on a rising xadc_dclk edge where
    // m_axis_tvalid & m_axis_tready; once tvalid rises, tvalid/tdata/tid/tlast/tuser
    // stay unchanged until that transfer, and tvalid never drops without it.

    localparam int         TW        = (DRP_TIMEOUT_CYCLES > 2) ? $clog2(DRP_TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(DRP_TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SEND
    } state_t;

    state_t                state, state_next;
    logic [3:0]            idx, idx_next;
    logic [TW-1:0]         timer, timer_next;
    logic [6:0]            daddr_next;
    logic                  den_next;
    logic [DATA_WIDTH-1:0] tdata_next;
    logic                  tvalid_next;
    logic [3:0]            tid_next;
    logic                  tlast_next;
    logic                  tuser_next;
    logic                  timeout_hit;

    // Table entry 0 sits in the most significant 7 bits of CHANNEL_ADDRS.
    function automatic logic [6:0] chan_addr(input logic [3:0] i);
        return CHANNEL_ADDRS[(NUM_CHANNELS - 1 - int'(i)) * 7 +: 7];
    endfunction

    assign busy = (state != S_IDLE);

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        timer_next  = timer;
        daddr_next  = xadc_daddr;
        den_next    = 1'b0;
        tdata_next  = m_axis_tdata;
        tvalid_next = m_axis_tvalid;
        tid_next    = m_axis_tid;
        tlast_next  = m_axis_tlast;
        tuser_next  = m_axis_tuser;
        timeout_hit = 1'b0;

        // Outputs are registered from the next state, so den is high exactly
        // during the single ISSUE cycle and tvalid exactly while in SEND.
        case (state)
            S_IDLE: begin
                if (xadc_eos && enable) begin
                    state_next = S_ISSUE;
                    idx_next   = 4'd0;
                    den_next   = 1'b1;
                    daddr_next = chan_addr(4'd0);
                end
            end
            S_ISSUE: begin
                timer_next = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (xadc_drdy) begin
                    state_next  = S_SEND;
                    tdata_next  = xadc_do;
                    tuser_next  = 1'b0;
                    tvalid_next = 1'b1;
                    tid_next    = idx;
                    tlast_next  = (idx == LAST_IDX);
                end else if (timer == TIMER_LAST) begin
                    state_next  = S_SEND;
                    tdata_next  = '0;
                    tuser_next  = 1'b1;
                    tvalid_next = 1'b1;
                    tid_next    = idx;
                    tlast_next  = (idx == LAST_IDX);
                    timeout_hit = 1'b1;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    tvalid_next = 1'b0;
                    if (m_axis_tlast) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_ISSUE;
                        idx_next   = idx + 4'd1;
                        den_next   = 1'b1;
                        daddr_next = chan_addr(idx + 4'd1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
        if (!xadc_reset_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            timer         <= '0;
            xadc_daddr    <= '0;
            xadc_den      <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tid    <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            overrun_count <= '0;
            timeout_count <= '0;
        end else begin
            state         <= state_next;
            idx           <= idx_next;
            timer         <= timer_next;
            xadc_daddr    <= daddr_next;
            xadc_den      <= den_next;
            m_axis_tdata  <= tdata_next;
            m_axis_tvalid <= tvalid_next;
            m_axis_tid    <= tid_next;
            m_axis_tlast  <= tlast_next;
            m_axis_tuser  <= tuser_next;
            // An EOS seen in any non-IDLE state is dropped, including the final SEND cycle.
            if (xadc_eos && (state != S_IDLE) && (overrun_count != '1))
                overrun_count <= overrun_count + CNT_WIDTH'(1);
            if (timeout_hit && (timeout_count != '1))
                timeout_count <= timeout_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_xadc_drp_multichannel_sequencer.sv
// Directed bench: table of sweep scenarios plus hand-written stall, reset and enable sequences.
module tb_xadc_drp_multichannel_sequencer;

  logic        xadc_dclk = 1'b0;
  logic        xadc_reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        xadc_drdy = 1'b0;
  logic [15:0] xadc_do = 16'hDEAD;
  logic        xadc_eos = 1'b0;
  logic        m_axis_tready = 1'b1;

  logic [6:0]  xadc_daddr;
  logic        xadc_den;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic [3:0]  m_axis_tid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy;
  logic [15:0] overrun_count;
  logic [15:0] timeout_count;

  logic [6:0]  sat_daddr;
  logic        sat_den;
  logic [15:0] sat_tdata;
  logic        sat_tvalid;
  logic [3:0]  sat_tid;
  logic        sat_tlast;
  logic        sat_tuser;
  logic        sat_busy;
  logic [1:0]  sat_ovr;
  logic [1:0]  sat_tout;

  xadc_drp_multichannel_sequencer dut (
    .xadc_dclk(xadc_dclk), .xadc_reset_n(xadc_reset_n), .enable(enable),
    .xadc_daddr(xadc_daddr), .xadc_den(xadc_den), .xadc_drdy(xadc_drdy),
    .xadc_do(xadc_do), .xadc_eos(xadc_eos),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tid(m_axis_tid), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .overrun_count(overrun_count), .timeout_count(timeout_count)
  );

  // Narrow-counter copy sharing all stimulus, used to observe saturation.
  xadc_drp_multichannel_sequencer #(.CNT_WIDTH(2)) u_sat (
    .xadc_dclk(xadc_dclk), .xadc_reset_n(xadc_reset_n), .enable(enable),
    .xadc_daddr(sat_daddr), .xadc_den(sat_den), .xadc_drdy(xadc_drdy),
    .xadc_do(xadc_do), .xadc_eos(xadc_eos),
    .m_axis_tdata(sat_tdata), .m_axis_tvalid(sat_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tid(sat_tid), .m_axis_tlast(sat_tlast), .m_axis_tuser(sat_tuser),
    .busy(sat_busy), .overrun_count(sat_ovr), .timeout_count(sat_tout)
  );

  // clock / reset
  always #5 xadc_dclk = ~xadc_dclk;

  int cyc = 0;
  always @(posedge xadc_dclk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  tid;
    logic [15:0] tdata;
    logic        tlast;
    logic        tuser;
    int          cyc;
  } beat_t;

  typedef struct {
    logic       en;
    int         delay;
    logic [6:0] sup;
    int         extra_eos;
    int         exp_tout;
    int         exp_ovr;
  } row_t;

  logic [6:0]  addr_tbl [4] = '{7'h13, 7'h1B, 7'h03, 7'h00};
  beat_t       beat_q[$];
  logic [6:0]  den_addr_q[$];
  int          den_cyc_q[$];
  logic [15:0] exp_q[$];

  int          total = 0;
  int          bad = 0;
  int          sweep_no = 0;
  int          eos_cyc = 0;
  int          rsp_delay = 2;
  logic [6:0]  sup_addr = 7'h7F;
  int          rsp_cnt = 0;
  logic [6:0]  rsp_addr = 7'h00;
  int          den_viol = 0;
  logic        in_beat = 1'b0;
  int          beat_start = 0;

  function automatic logic [15:0] model_data(input logic [6:0] addr, input int sw);
    logic [4:0] s;
    s = sw[4:0];
    return {4'hA, s, addr};
  endfunction

  // DRP responder: drdy follows den by rsp_delay cycles unless the address is suppressed.
  always @(negedge xadc_dclk) begin
    xadc_drdy = 1'b0;
    xadc_do   = 16'hDEAD;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        xadc_drdy = 1'b1;
        xadc_do   = model_data(rsp_addr, sweep_no);
      end
    end
    if (xadc_den) begin
      if (rsp_cnt > 0) den_viol++;
      den_addr_q.push_back(xadc_daddr);
      den_cyc_q.push_back(cyc);
      if (xadc_daddr != sup_addr) begin
        rsp_cnt  = rsp_delay;
        rsp_addr = xadc_daddr;
      end
    end
  end

  // stream monitor
  always @(negedge xadc_dclk) begin
    if (!xadc_reset_n) begin
      in_beat = 1'b0;
    end else if (m_axis_tvalid) begin
      if (!in_beat) begin
        in_beat    = 1'b1;
        beat_start = cyc;
      end
      if (m_axis_tready) begin
        beat_q.push_back('{m_axis_tid, m_axis_tdata, m_axis_tlast, m_axis_tuser, beat_start});
        in_beat = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge xadc_dclk);
    #1;
  endtask

  task automatic clear_logs();
    beat_q.delete();
    den_addr_q.delete();
    den_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_eos();
    xadc_eos = 1'b1;
    eos_cyc  = cyc;
    tick();
    xadc_eos = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_done"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid_tid(input logic [3:0] id, output logic found);
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge xadc_dclk);
      if (m_axis_tvalid && m_axis_tid == id) found = 1'b1;
    end
  endtask

  // Compares one completed sweep against the address table and the DRP data model.
  task automatic check_sweep(input string tag, input int delay, input logic [6:0] sup, input int exp_n);
    logic [15:0] e;
    int          lat;
    check({tag, "_beats"}, 32'(beat_q.size()), 32'(exp_n));
    check({tag, "_dens"}, 32'(den_addr_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      if (i < beat_q.size() && i < den_addr_q.size()) begin
        exp_q.push_back((addr_tbl[i] == sup) ? 16'h0000 : model_data(addr_tbl[i], sweep_no));
        e = exp_q.pop_front();
        lat = (addr_tbl[i] == sup) ? 65 : delay + 1;
        check($sformatf("%s_b%0d_daddr", tag, i), 32'(den_addr_q[i]), 32'(addr_tbl[i]));
        check($sformatf("%s_b%0d_tid", tag, i), 32'(beat_q[i].tid), 32'(i));
        check($sformatf("%s_b%0d_tdata", tag, i), 32'(beat_q[i].tdata), 32'(e));
        check($sformatf("%s_b%0d_tlast", tag, i), 32'(beat_q[i].tlast), 32'(i == 3));
        check($sformatf("%s_b%0d_tuser", tag, i), 32'(beat_q[i].tuser), 32'(addr_tbl[i] == sup));
        check($sformatf("%s_b%0d_lat", tag, i), 32'(beat_q[i].cyc - den_cyc_q[i]), 32'(lat));
      end
    end
    if (exp_n > 0 && beat_q.size() > 0)
      check({tag, "_first_lat"}, 32'(beat_q[0].cyc - eos_cyc), 32'(delay + 2));
  endtask

  row_t tbl [5];

  initial begin
    logic        found;
    logic [15:0] hold_data;
    int          hold_bad;
    int          dens_before;
    int          n;

    tbl[0] = '{1'b0, 2, 7'h7F, 0, 0, 0};
    tbl[1] = '{1'b1, 2, 7'h7F, 0, 0, 0};
    tbl[2] = '{1'b1, 1, 7'h7F, 0, 0, 0};
    tbl[3] = '{1'b1, 2, 7'h03, 0, 1, 0};
    tbl[4] = '{1'b1, 3, 7'h7F, 3, 1, 3};

    repeat (3) tick();
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_den", 32'(xadc_den), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_daddr", 32'(xadc_daddr), 32'd0);
    check("rst_ovr", 32'(overrun_count), 32'd0);
    xadc_reset_n = 1'b1;
    repeat (2) tick();

    for (int r = 0; r < 5; r++) begin
      clear_logs();
      rsp_delay = tbl[r].delay;
      sup_addr  = tbl[r].sup;
      enable    = tbl[r].en;
      sweep_no++;
      pulse_eos();
      for (int k = 0; k < tbl[r].extra_eos; k++) begin
        repeat (3) tick();
        xadc_eos = 1'b1;
        tick();
        xadc_eos = 1'b0;
      end
      if (tbl[r].en) wait_idle($sformatf("row%0d", r));
      else repeat (20) tick();
      repeat (5) tick();
      check_sweep($sformatf("row%0d", r), tbl[r].delay, tbl[r].sup, tbl[r].en ? 4 : 0);
      check($sformatf("row%0d_tout", r), 32'(timeout_count), 32'(tbl[r].exp_tout));
      check($sformatf("row%0d_ovr", r), 32'(overrun_count), 32'(tbl[r].exp_ovr));
      check($sformatf("row%0d_sat_ovr", r), 32'(sat_ovr), 32'((tbl[r].exp_ovr > 3) ? 3 : tbl[r].exp_ovr));
    end
    sup_addr = 7'h7F;

    // Stall beat 1 for 20 cycles; an EOS during the stall pushes the counters past the narrow copy's limit.
    clear_logs();
    rsp_delay = 2;
    enable = 1'b1;
    sweep_no++;
    pulse_eos();
    wait_valid_tid(4'd0, found);
    check("t2_beat0_seen", 32'(found), 32'd1);
    @(posedge xadc_dclk);
    #1;
    m_axis_tready = 1'b0;
    wait_valid_tid(4'd1, found);
    check("t2_beat1_seen", 32'(found), 32'd1);
    hold_data   = m_axis_tdata;
    dens_before = den_addr_q.size();
    check("t2_hold_data", 32'(hold_data), 32'(model_data(7'h1B, sweep_no)));
    tick();
    xadc_eos = 1'b1;
    tick();
    xadc_eos = 1'b0;
    hold_bad = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge xadc_dclk);
      if (!m_axis_tvalid || m_axis_tid != 4'd1 || m_axis_tdata != hold_data) hold_bad++;
    end
    check("t2_hold_stable", 32'(hold_bad), 32'd0);
    check("t2_no_den", 32'(den_addr_q.size()), 32'(dens_before));
    tick();
    m_axis_tready = 1'b1;
    wait_idle("t2");
    repeat (5) tick();
    check("t2_beats", 32'(beat_q.size()), 32'd4);
    if (beat_q.size() == 4) check("t2_b3_tdata", 32'(beat_q[3].tdata), 32'(model_data(7'h00, sweep_no)));
    check("t2_ovr", 32'(overrun_count), 32'd4);
    check("t4_sat_ovr", 32'(sat_ovr), 32'd3);

    // Asynchronous reset while waiting on channel 1.
    clear_logs();
    rsp_delay = 10;
    sweep_no++;
    pulse_eos();
    n = 0;
    while (den_addr_q.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    check("t5_reach_ch1", 32'(den_addr_q.size()), 32'd2);
    repeat (2) tick();
    check("t5_busy_before", 32'(busy), 32'd1);
    #2;
    xadc_reset_n = 1'b0;
    #1;
    check("t5_daddr", 32'(xadc_daddr), 32'd0);
    check("t5_den", 32'(xadc_den), 32'd0);
    check("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t5_tdata", 32'(m_axis_tdata), 32'd0);
    check("t5_tid", 32'(m_axis_tid), 32'd0);
    check("t5_tlast_tuser", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ovr", 32'(overrun_count), 32'd0);
    check("t5_tout", 32'(timeout_count), 32'd0);
    repeat (3) tick();
    xadc_reset_n = 1'b1;
    clear_logs();
    repeat (30) tick();
    check("t5_quiet_dens", 32'(den_addr_q.size()), 32'd0);
    check("t5_quiet_beats", 32'(beat_q.size()), 32'd0);
    check("t5_quiet_busy", 32'(busy), 32'd0);
    rsp_delay = 2;
    sweep_no++;
    pulse_eos();
    wait_idle("t5_after");
    repeat (5) tick();
    check_sweep("t5_after", 2, 7'h7F, 4);

    // Dropping enable mid-sweep still finishes the sweep.
    clear_logs();
    sweep_no++;
    pulse_eos();
    wait_valid_tid(4'd1, found);
    check("t6_beat1_seen", 32'(found), 32'd1);
    tick();
    enable = 1'b0;
    wait_idle("t6");
    repeat (5) tick();
    check_sweep("t6", 2, 7'h7F, 4);
    check("t6_ovr", 32'(overrun_count), 32'd0);

    check("den_never_early", 32'(den_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
